wb_scr_mem_arbiter: RTL
=======================

# wb_scr_mem_arbiter

Shares one Wishbone master port between the SCR1 instruction-memory (IMEM) and data-memory (DMEM) request interfaces. Accepts single-beat requests and arbitrates round-robin when both are pending. Runs a classic Wishbone cycle, then returns read data and an OK/ER response to the granted requester. Sits between the SCR1 core memory interfaces and the shared Wishbone interconnect.

## Interface
- `TIMEOUT`, 255: cycles a bus cycle may stay unacknowledged before forced termination; 8-bit counter; 0 disables the timeout.
- `wb_clk_i`  in  1  clock, all logic on rising edge
- `wb_rst_i`  in  1  reset, asynchronous, active-high
- `imem_req`  in  1  IMEM request (read only)
- `imem_addr`  in  32  IMEM byte address
- `imem_req_ack`  out  1  one-cycle pulse: IMEM request latched
- `imem_rdata`  out  32  IMEM read data, valid with `imem_resp`≠NOTRDY
- `imem_resp`  out  2  NOTRDY=00, OK=01, ER=10; one-cycle pulse
- `dmem_req`  in  1  DMEM request
- `dmem_cmd`  in  1  0=read, 1=write
- `dmem_width`  in  2  00=byte, 01=half, 10=word
- `dmem_addr`  in  32  DMEM byte address
- `dmem_wdata`  in  32  write data, already lane-aligned
- `dmem_req_ack`, `dmem_rdata`, `dmem_resp`  out  1/32/2  same semantics as IMEM
- `wbm_adr_o`  out  32  word-aligned address (`addr[1:0]` forced 00)
- `wbm_dat_o`  out  32  write data
- `wbm_dat_i`  in  32  read data
- `wbm_we_o`  out  1  write enable
- `wbm_sel_o`  out  4  byte lane select
- `wbm_stb_o`, `wbm_cyc_o`  out  1  strobe / cycle
- `wbm_ack_i`, `wbm_err_i`  in  1  slave acknowledge / error

## Operation
- Reset: all outputs 0; state IDLE; `last_grant`=DMEM, so IMEM wins the first conflict; timeout counter 0.
- IDLE:
  - One requester high: grant it.
  - Both high: grant the one not in `last_grant`.
  - On grant: latch addr/cmd/width/wdata; pulse that requester's `req_ack`; update `last_grant`.
  - Legal request: drive `cyc`=`stb`=1, go to BUS.
  - Illegal request (misaligned half with `addr[0]`=1, misaligned word with `addr[1:0]`≠0, or width=11): no bus cycle; go to RESP with ER.
- `sel` generation:
  - byte: `4'b0001<<addr[1:0]`
  - half: `4'b0011<<addr[1:0]`
  - word: `4'b1111`
  - IMEM requests are always word reads.
- BUS:
  - `wbm_ack_i`: capture `wbm_dat_i`, result OK. `wbm_err_i`: result ER; takes priority if it arrives in the same cycle as ack.
  - Counter reaches TIMEOUT: result ER.
  - Any of the above: deassert `cyc`/`stb`/`we`, go to RESP.
- RESP: drive granted requester's `resp` (OK/ER) and `rdata` for one cycle; `rdata`=0 on ER and on writes; return to IDLE.
- Non-granted requester: `resp` stays NOTRDY and `req_ack` stays 0; its request stays pending.

## Timing
- Request sampled high at edge N in IDLE:
  - `req_ack`=1 and `cyc`/`stb`=1 during cycle N+1.
- Ack sampled at edge M:
  - `cyc`/`stb` low and `resp`/`rdata` valid during cycle M+1.
  - Back in IDLE at M+2; a new grant may be issued at edge M+2.
- Minimum transaction: 3 cycles with a zero-wait slave; no back-to-back bus cycles.
- Address/data/sel/we stay stable for the whole BUS state.
- Timeout: ER response in the cycle after the counter reaches TIMEOUT; counter clears in IDLE.
- `wb_rst_i` asserted mid-cycle: outputs drop to 0 immediately and asynchronously; no response is issued for the aborted transaction.

## Structure
- Shared package `wb_scr_pkg`:
  - state enum IDLE/BUS/RESP
  - resp codes NOTRDY/OK/ER (matching SCR1 memif encoding)
  - width codes BYTE/HALF/WORD
  - grant enum IMEM/DMEM
- Sub-module `wb_sel_gen` (combinational): width + `addr[1:0]` → `sel[3:0]` + `misaligned` flag.
- Top module holds the FSM, round-robin grant, request latch and timeout counter.

## Test plan
- IMEM read of 0x0000_0104, slave acks 1 cycle later with 0xDEADBEEF:
  - `imem_req_ack` pulse
  - `wbm_adr_o`=0x104, `sel`=1111, `we`=0
  - `imem_resp`=OK with `rdata`=0xDEADBEEF, 3 cycles total
- IMEM and DMEM request on the same edge after reset, both held:
  - IMEM granted first, DMEM second
  - IMEM granted again on its next repeat (alternating)
- DMEM byte write 0x55 at 0x1003: `sel`=1000, `adr`=0x1000, `we`=1 → `dmem_resp`=OK, `dmem_rdata`=0.
- DMEM half read at 0x2001: no `cyc`; `dmem_resp`=ER one cycle after `req_ack`.
- Timeouts:
  - TIMEOUT=4, slave never acks: `cyc` drops and `resp`=ER after 4 BUS cycles.
  - `wbm_err_i` together with ack gives ER.
- Reset asserted during BUS: `cyc`/`stb` go 0 asynchronously; after release, the next IMEM request completes normally.

Source files
------------

// File: rtl/wb_scr_pkg.sv
// Shared types for the SCR1 IMEM/DMEM to Wishbone arbiter.
package wb_scr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RESP_NOTRDY = 2'b00,
    RESP_OK     = 2'b01,
    RESP_ER     = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'b00,
    WIDTH_HALF = 2'b01,
    WIDTH_WORD = 2'b10
  } width_e;

  typedef enum logic {
    GNT_IMEM = 1'b0,
    GNT_DMEM = 1'b1
  } grant_e;

endpackage

// File: rtl/wb_sel_gen.sv
// Byte-lane select and alignment check for a single-beat access.
module wb_sel_gen
  import wb_scr_pkg::*;
(
  input  logic [1:0] width,
  input  logic [1:0] addr_lo,
  output logic [3:0] sel,
  output logic       misaligned
);

  always_comb begin
    sel        = '0;
    misaligned = 1'b0;
    case (width)
      WIDTH_BYTE: sel = 4'b0001 << addr_lo;
      WIDTH_HALF: begin
        sel        = 4'b0011 << addr_lo;
        misaligned = addr_lo[0];
      end
      WIDTH_WORD: begin
        sel        = 4'b1111;
        misaligned = |addr_lo;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_scr_mem_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone master between SCR1 IMEM and DMEM.
module wb_scr_mem_arbiter
  import wb_scr_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic        imem_req_ack,
  output logic [31:0] imem_rdata,
  output logic [1:0]  imem_resp,
  input  logic        dmem_req,
  input  logic        dmem_cmd,
  input  logic [1:0]  dmem_width,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_req_ack,
  output logic [31:0] dmem_rdata,
  output logic [1:0]  dmem_resp,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q, state_d;
  grant_e      last_q, last_d, gnt_q, gnt_d, pick;
  resp_e       resp_q, resp_d;
  logic [31:0] adr_q, adr_d, wdat_q, wdat_d, rdata_q, rdata_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic        we_q, we_d, bad_q, bad_d;
  logic        iack_q, iack_d, dack_q, dack_d;
  logic [31:0] req_addr;
  logic [1:0]  req_width;
  logic [3:0]  req_sel;
  logic        req_misaligned;

  always_comb begin
    if (imem_req && dmem_req) begin
      if (last_q == GNT_IMEM) pick = GNT_DMEM;
      else                    pick = GNT_IMEM;
    end else if (imem_req) begin
      pick = GNT_IMEM;
    end else begin
      pick = GNT_DMEM;
    end
    req_addr  = (pick == GNT_IMEM) ? imem_addr : dmem_addr;
    req_width = (pick == GNT_IMEM) ? WIDTH_WORD : dmem_width;
  end

  wb_sel_gen u_sel_gen (
    .width      (req_width),
    .addr_lo    (req_addr[1:0]),
    .sel        (req_sel),
    .misaligned (req_misaligned)
  );

  assign cnt_inc = cnt_q + 8'd1;

  // Illegal requests still pass through BUS (with cyc/stb gated off) so their
  // ER response lands one cycle after req_ack, like a zero-wait bus cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    resp_d  = resp_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    bad_d   = bad_q;
    iack_d  = 1'b0;
    dack_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (imem_req || dmem_req) begin
          gnt_d   = pick;
          last_d  = pick;
          iack_d  = (pick == GNT_IMEM);
          dack_d  = (pick == GNT_DMEM);
          adr_d   = {req_addr[31:2], 2'b00};
          wdat_d  = (pick == GNT_DMEM) ? dmem_wdata : '0;
          we_d    = (pick == GNT_DMEM) && dmem_cmd;
          sel_d   = req_sel;
          bad_d   = req_misaligned;
          rdata_d = '0;
          resp_d  = req_misaligned ? RESP_ER : RESP_NOTRDY;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        cnt_d = cnt_inc;
        if (bad_q) begin
          state_d = ST_RESP;
        end else if (wbm_err_i) begin
          resp_d  = RESP_ER;
          state_d = ST_RESP;
        end else if (wbm_ack_i) begin
          resp_d  = RESP_OK;
          rdata_d = we_q ? '0 : wbm_dat_i;
          state_d = ST_RESP;
        end else if ((TIMEOUT_C != '0) && (cnt_inc == TIMEOUT_C)) begin
          resp_d  = RESP_ER;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= GNT_DMEM;
      gnt_q   <= GNT_IMEM;
      resp_q  <= RESP_NOTRDY;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      iack_q  <= 1'b0;
      dack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      resp_q  <= resp_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      bad_q   <= bad_d;
      iack_q  <= iack_d;
      dack_q  <= dack_d;
    end
  end

  assign wbm_cyc_o    = (state_q == ST_BUS) && !bad_q;
  assign wbm_stb_o    = wbm_cyc_o;
  assign wbm_we_o     = wbm_cyc_o && we_q;
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = wdat_q;
  assign wbm_sel_o    = sel_q;
  assign imem_req_ack = iack_q;
  assign dmem_req_ack = dack_q;
  assign imem_resp    = ((state_q == ST_RESP) && (gnt_q == GNT_IMEM)) ? resp_q : RESP_NOTRDY;
  assign dmem_resp    = ((state_q == ST_RESP) && (gnt_q == GNT_DMEM)) ? resp_q : RESP_NOTRDY;
  assign imem_rdata   = ((state_q == ST_RESP) && (gnt_q == GNT_IMEM)) ? rdata_q : '0;
  assign dmem_rdata   = ((state_q == ST_RESP) && (gnt_q == GNT_DMEM)) ? rdata_q : '0;

endmodule
